mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (stage 1, read-only) and the load-store requester (stage 5, read/write).
- Issues at most one memory access per cycle. Priority goes to load-store, with a starvation guard for fetch.
- Routes returned read data to the requester that issued the access, using an in-flight owner pipeline that matches the fixed memory read latency.
- Sits between Core's fetch/load-store ports and the memory model.

Parameters:
- XLEN, 32: address/data width.
- MEM_LATENCY, 1: cycles from accepted mem_req to mem_rdata valid; legal range 1..4.
- MAX_LS_STREAK, 4: consecutive load-store grants allowed while fetch waits; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  XLEN  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  XLEN  fetched instruction.
- ls_req  in  1  load/store request; held stable until ls_gnt.
- ls_write  in  1  1=store, 0=load.
- ls_addr  in  XLEN  data address.
- ls_wdata  in  XLEN  store data.
- ls_be  in  4  byte enables (store).
- ls_gnt  out  1  load/store accepted this cycle.
- ls_rvalid  out  1  ls_rdata valid (loads only).
- ls_rdata  out  XLEN  load data.
- mem_req  out  1  memory access strobe.
- mem_write  out  1  memory write.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  XLEN  memory read data, valid MEM_LATENCY cycles after the read was accepted.

Behaviour:
- Reset (rstn=0, async):
  - streak counter = 0; owner pipeline = all NONE.
  - if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid = 0.
  - rdata outputs = 0.
  - All grants and mem_req are forced to 0 while rstn=0.
- Grant logic is combinational in the same cycle as the request; memory accepts every mem_req.
  - Only ls_req: grant LS.
  - Only if_req: grant IF.
  - Both: grant LS unless streak == MAX_LS_STREAK, in which case grant IF.
  - Neither: mem_req=0.
- At most one of if_gnt/ls_gnt is high; mem_req = if_gnt | ls_gnt.
- Memory output mux:
  - IF grant: mem_write=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0.
  - LS grant: mem_write=ls_write, mem_be=ls_be, mem_addr=ls_addr, mem_wdata=ls_wdata.
  - No grant: all memory outputs = 0.
- Streak counter (4-bit, registered):
  - LS granted while if_req=1: increment, saturating at MAX_LS_STREAK.
  - IF granted, or if_req=0: clear to 0.
- Owner pipeline: MEM_LATENCY-deep shift register of 2-bit tags {NONE, IF, LS}.
  - Stage 0 is loaded each cycle: IF for an IF grant, LS for an LS load grant, NONE for a store or idle cycle.
- Response:
  - When the tag exiting the pipeline this cycle is IF: if_rvalid=1 and if_rdata=mem_rdata.
  - When it is LS: ls_rvalid=1 and ls_rdata=mem_rdata.
  - rvalid outputs are combinational from the tag, and only one is high per cycle.
  - rdata holds its last value when rvalid=0.
- Stores produce no rvalid. Back-to-back accesses are fully pipelined: one grant per cycle, responses in grant order.
- Reset mid-operation clears in-flight tags. No rvalid is issued for accesses granted before reset, even if mem_rdata toggles afterwards.
- The streak guard bounds fetch wait to MAX_LS_STREAK+1 cycles.

Test Plan:
- Only if_req=1, if_addr=0x100; memory returns 0x00500093 one cycle later (MEM_LATENCY=1) -> if_gnt=1 same cycle, mem_addr=0x100, mem_write=0; next cycle if_rvalid=1, if_rdata=0x00500093, ls_rvalid=0.
- Both requests in the same cycle; ls load to addr 0x2000 -> ls_gnt=1, if_gnt=0; mem_addr=0x2000; ls_rvalid 1 cycle later. IF is granted the following cycle once ls_req drops.
- ls_req and if_req held high continuously, MAX_LS_STREAK=4 -> grant pattern LS,LS,LS,LS,IF,LS,LS,LS,LS,IF...; streak returns to 0 after each IF grant.
- Store: ls_write=1, ls_addr=0x2004, ls_wdata=0xDEADBEEF, ls_be=4'b0011 -> mem_write=1, mem_wdata=0xDEADBEEF, mem_be=4'b0011; no ls_rvalid in the following MEM_LATENCY cycles.
- MEM_LATENCY=3; grants IF, LS-load, store, IF on cycles 0-3 -> if_rvalid on cycle 3, ls_rvalid on cycle 4, nothing on cycle 5, if_rvalid on cycle 6.
- Grant IF at cycle 0 (MEM_LATENCY=2); assert rstn=0 at cycle 1 and release at cycle 2 -> all outputs 0 immediately at reset assertion; no if_rvalid at cycle 2 or later; streak=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and
// load-store. Load-store wins conflicts unless fetch has been starved for
// MAX_LS_STREAK consecutive grants. Read data is routed back to its requester
// through an owner-tag pipeline that matches the fixed memory read latency.
module mem_port_arbiter #(
  parameter int XLEN          = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic            clk,
  input  logic            rstn,
  // Fetch requester (read-only)
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  // Load-store requester
  input  logic            ls_req,
  input  logic            ls_write,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  // Memory side
  output logic            mem_req,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [3:0]      r_streak;
  owner_e          r_owner [MEM_LATENCY];
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_ls_rdata;

  logic            w_if_gnt;
  logic            w_ls_gnt;
  owner_e          w_tag_in;
  owner_e          w_tag_out;

  // Arbitration: load-store first, fetch forced through once the streak saturates.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (rstn) begin
      if (ls_req && !(if_req && (r_streak == STREAK_MAX))) begin
        w_ls_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  assign if_gnt  = w_if_gnt;
  assign ls_gnt  = w_ls_gnt;
  assign mem_req = w_if_gnt | w_ls_gnt;

  // Memory request mux: the granted requester drives the port, idle drives zeros.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
      mem_be   = 4'hF;
    end else if (w_ls_gnt) begin
      mem_write = ls_write;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end
  end

  // Streak of load-store grants taken while fetch was waiting.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_streak <= 4'd0;
    end else if (w_ls_gnt && if_req) begin
      if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 4'd1;
      end
    end else begin
      r_streak <= 4'd0;
    end
  end

  // Tag entering the pipeline: stores and idle cycles expect no read data.
  always_comb begin
    w_tag_in = OWN_NONE;
    if (w_if_gnt) begin
      w_tag_in = OWN_IF;
    end else if (w_ls_gnt && !ls_write) begin
      w_tag_in = OWN_LS;
    end
  end

  // Owner pipeline, one stage per cycle of memory read latency.
  // NOTE: this small tag array is reset, unlike data RAMs, so reset cancels in-flight reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_owner[i] <= OWN_NONE;
      end
    end else begin
      r_owner[0] <= w_tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_owner[i] <= r_owner[i-1];
      end
    end
  end

  assign w_tag_out = r_owner[MEM_LATENCY-1];
  assign if_rvalid = (w_tag_out == OWN_IF);
  assign ls_rvalid = (w_tag_out == OWN_LS);

  // Hold registers keep the last delivered word visible while rvalid is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      if (if_rvalid) r_if_rdata <= mem_rdata;
      if (ls_rvalid) r_ls_rdata <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : r_if_rdata;
  assign ls_rdata = ls_rvalid ? mem_rdata : r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share the
// same requester stimulus. Grants and the memory port are checked in the
// grant cycle; read responses go through a per-instance scoreboard queue
// that a monitor drains whenever rvalid is seen.
module tb_mem_port_arbiter;

  typedef enum logic [1:0] {G_NONE, G_IF, G_LS} gnt_e;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_write;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;

  logic [1:0]       if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_write;
  logic [1:0][31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_be;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q [2][$];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Memory contents: one known instruction word, everything else address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] rd_pipe [L];
    logic [31:0] last_if;
    logic [31:0] last_ls;
    exp_t        e;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(L), .MAX_LS_STREAK(4)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .ls_req    (ls_req),
      .ls_write  (ls_write),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_be     (ls_be),
      .ls_gnt    (ls_gnt[g]),
      .ls_rvalid (ls_rvalid[g]),
      .ls_rdata  (ls_rdata[g]),
      .mem_req   (mem_req[g]),
      .mem_write (mem_write[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_be    (mem_be[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Fixed-latency memory model; non-read cycles return a junk pattern.
    always @(posedge clk) begin
      rd_pipe[0] <= (mem_req[g] && !mem_write[g]) ? mem_word(mem_addr[g])
                                                  : (32'hBAD0_0000 | 32'(cyc));
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata[g] = rd_pipe[L-1];

    // Response monitor: pop and compare on rvalid, otherwise check rdata holds.
    always @(negedge clk) begin
      if (!rstn) begin
        last_if = 32'h0;
        last_ls = 32'h0;
      end else if (if_rvalid[g] || ls_rvalid[g]) begin
        check($sformatf("d%0d rvalid onehot", g), 32'(if_rvalid[g] & ls_rvalid[g]), 32'h0);
        if (sb_q[g].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL d%0d unexpected rvalid: if_rvalid=%b ls_rvalid=%b, expected none (cycle %0d)",
                   g, if_rvalid[g], ls_rvalid[g], cyc);
        end else begin
          e = sb_q[g].pop_front();
          check($sformatf("d%0d resp owner if", g), 32'(if_rvalid[g]), 32'(e.is_if));
          check($sformatf("d%0d resp cycle", g), 32'(cyc), 32'(e.due));
          if (e.is_if) begin
            check($sformatf("d%0d if_rdata", g), if_rdata[g], e.data);
            last_if = e.data;
          end else begin
            check($sformatf("d%0d ls_rdata", g), ls_rdata[g], e.data);
            last_ls = e.data;
          end
        end
      end else begin
        check($sformatf("d%0d if_rdata hold", g), if_rdata[g], last_if);
        check($sformatf("d%0d ls_rdata hold", g), ls_rdata[g], last_ls);
      end
    end
  end

  // One cycle of requests; checks grants and memory port, queues read responses.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [31:0] la, input logic [31:0] lwd, input logic [3:0] lbe,
                      input gnt_e eg);
    exp_t x;
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia;
    ls_req = lr; ls_write = lw; ls_addr = la; ls_wdata = lwd; ls_be = lbe;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d if_gnt", g),  32'(if_gnt[g]),  32'(eg == G_IF));
      check($sformatf("d%0d ls_gnt", g),  32'(ls_gnt[g]),  32'(eg == G_LS));
      check($sformatf("d%0d mem_req", g), 32'(mem_req[g]), 32'(eg != G_NONE));
      check($sformatf("d%0d mem_write", g), 32'(mem_write[g]), 32'((eg == G_LS) && lw));
      check($sformatf("d%0d mem_addr", g), mem_addr[g],
            (eg == G_IF) ? ia : (eg == G_LS) ? la : 32'h0);
      check($sformatf("d%0d mem_wdata", g), mem_wdata[g], (eg == G_LS) ? lwd : 32'h0);
      check($sformatf("d%0d mem_be", g), 32'(mem_be[g]),
            (eg == G_IF) ? 32'hF : (eg == G_LS) ? 32'(lbe) : 32'h0);
      if (eg == G_IF) begin
        x.is_if = 1'b1; x.data = mem_word(ia); x.due = cyc + lat(g);
        sb_q[g].push_back(x);
      end else if (eg == G_LS && !lw) begin
        x.is_if = 1'b0; x.data = mem_word(la); x.due = cyc + lat(g);
        sb_q[g].push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, G_NONE);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s d%0d if_gnt", tag, g),    32'(if_gnt[g]),    32'h0);
      check($sformatf("%s d%0d ls_gnt", tag, g),    32'(ls_gnt[g]),    32'h0);
      check($sformatf("%s d%0d mem_req", tag, g),   32'(mem_req[g]),   32'h0);
      check($sformatf("%s d%0d if_rvalid", tag, g), 32'(if_rvalid[g]), 32'h0);
      check($sformatf("%s d%0d ls_rvalid", tag, g), 32'(ls_rvalid[g]), 32'h0);
      check($sformatf("%s d%0d if_rdata", tag, g),  if_rdata[g],       32'h0);
      check($sformatf("%s d%0d ls_rdata", tag, g),  ls_rdata[g],       32'h0);
      check($sformatf("%s d%0d mem_addr", tag, g),  mem_addr[g],       32'h0);
      check($sformatf("%s d%0d mem_be", tag, g),    32'(mem_be[g]),    32'h0);
    end
  endtask

  initial begin
    gnt_e        pat [10];
    logic [31:0] ia;
    logic [31:0] la;
    pat = '{G_LS, G_LS, G_LS, G_LS, G_IF, G_LS, G_LS, G_LS, G_LS, G_IF};

    // Reset with both requesters asserted: grants must stay low.
    rstn = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 32'h2000; ls_wdata = 32'h0; ls_be = 4'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    if_req = 1'b0; ls_req = 1'b0;
    rstn = 1'b1;

    // Fetch alone, then conflict resolved to load-store, fetch follows.
    step(1, 32'h100, 0, 0, 32'h0,    32'h0, 4'h0, G_IF);
    idle(1);
    step(1, 32'h104, 1, 0, 32'h2000, 32'h0, 4'hF, G_LS);
    step(1, 32'h104, 0, 0, 32'h0,    32'h0, 4'h0, G_IF);
    idle(3);

    // Continuous contention: fetch forced through after four load-store grants.
    ia = 32'h200;
    la = 32'h3000;
    for (int k = 0; k < 10; k++) begin
      step(1, ia, 1, 0, la, 32'h0, 4'hF, pat[k]);
      if (pat[k] == G_IF) ia += 32'h4;
      else la += 32'h4;
    end
    idle(3);

    // Store: full write path on the memory port, no read response.
    step(0, 32'h0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, G_LS);
    idle(4);

    // Mixed back-to-back sequence: fetch, load, store, fetch.
    step(1, 32'h300, 0, 0, 32'h0,    32'h0,         4'h0, G_IF);
    step(0, 32'h0,   1, 0, 32'h3100, 32'h0,         4'hF, G_LS);
    step(0, 32'h0,   1, 1, 32'h3104, 32'h1234_5678, 4'hF, G_LS);
    step(1, 32'h304, 0, 0, 32'h0,    32'h0,         4'h0, G_IF);
    idle(5);

    // Reset with reads in flight and a non-zero streak.
    step(1, 32'h400, 0, 0, 32'h0,    32'h0, 4'h0, G_IF);
    step(1, 32'h404, 1, 0, 32'h4000, 32'h0, 4'hF, G_LS);
    step(1, 32'h404, 1, 0, 32'h4004, 32'h0, 4'hF, G_LS);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    sb_q[0].delete();
    sb_q[1].delete();
    #1;
    check_reset_outputs("mid-reset");
    @(posedge clk);
    #1;
    if_req = 1'b0; ls_req = 1'b0;
    rstn = 1'b1;
    idle(4);

    // Streak restarts from zero after reset.
    ia = 32'h500;
    la = 32'h5000;
    for (int k = 0; k < 5; k++) begin
      step(1, ia, 1, 0, la, 32'h0, 4'hF, pat[k]);
      if (pat[k] == G_IF) ia += 32'h4;
      else la += 32'h4;
    end
    idle(6);

    for (int g = 0; g < 2; g++) begin
      check($sformatf("d%0d responses outstanding", g), 32'(sb_q[g].size()), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
